mc_core: RTL and testbench
==========================

MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; legal range 16..32.
REQ-002 Parameter NUM_REGS, default 32, register count; power of two, 2..32.
REQ-003 Parameter PC_W, default 16, word-address width of pc.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 imem_req  out  1  fetch request, held high until accepted.
REQ-007 imem_addr  out  PC_W  word address of the requested instruction; equals pc.
REQ-008 imem_ready  in  1  fetch accept; imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 pc  out  PC_W  current program counter.
REQ-011 alu_result  out  DATA_W  registered result of the last EXEC.
REQ-012 retire  out  1  one-cycle pulse when an instruction completes WB.
REQ-013 halted  out  1  high while in HALT.
REQ-014 illegal  out  1  sticky; set by an unrecognised opcode or funct.

Function
REQ-015 FSM states: FETCH, DECODE, EXEC, WB, HALT; FETCH->DECODE on imem_req&imem_ready, latching imem_rdata into instr.
REQ-016 DECODE->EXEC->WB->FETCH unconditionally; one instruction takes 4 cycles plus fetch wait cycles.
REQ-017 imem_req is high only in FETCH; imem_addr is stable while imem_req is high.
REQ-018 Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0]; register indices use the low log2(NUM_REGS) bits.
REQ-019 Operands are read in DECODE into A/B latches; the register file has 2 read ports and 1 write port, and writes occur only in WB.
REQ-020 Register 0 always reads 0; writes to it are discarded.
REQ-021 R-type (opcode 0x00) writes rd: funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed, result 1/0), 0x00 SLL B by shamt, 0x02 SRL B by shamt (logical).
REQ-022 ADDI (0x08) writes rt = A + sign-extended imm.
REQ-023 All arithmetic is modulo 2^DATA_W; overflow is ignored; shamt >= DATA_W yields 0.
REQ-024 BEQ (0x04) and BNE (0x05) compare A with B; if taken, pc <= pc + 1 + sign-extended imm in WB, otherwise pc <= pc + 1; no register write.
REQ-025 J (0x02) sets pc <= instr[PC_W-1:0] in WB.
REQ-026 All pc arithmetic wraps modulo 2^PC_W.
REQ-027 HALT (0x3F) moves WB->HALT; HALT holds all state and exits only on rst.
REQ-028 An unknown opcode or R-type funct executes as a NOP (pc+1, no write), sets illegal, and still pulses retire.
REQ-029 retire pulses in the WB cycle for every instruction, including branches, J, NOP and HALT.
REQ-030 alu_result updates at the end of EXEC; it carries the branch comparison difference A-B for BEQ/BNE and is unchanged for J/HALT.

Reset
REQ-031 While rst is high: state <= FETCH; pc, alu_result, retire, halted and illegal <= 0; all registers <= 0.
REQ-032 rst overrides every state, including a pending fetch; imem_req drops in the cycle after rst is sampled high, and an accept in that cycle is discarded.

Verification
REQ-033 ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 with imem_ready tied high -> r3=2, retire every 4th cycle, pc=3.
REQ-034 imem_ready held low 5 cycles in FETCH -> imem_req and imem_addr stable, no state advance; instruction then completes 3 cycles after accept.
REQ-035 r1=7, BEQ r1,r1,-1 at pc=10 -> pc=10 again; BNE r1,r1,+4 -> pc=11.
REQ-036 SLT r3,r2,r1 with r2=-1, r1=1 -> r3=1; SRL of 0x80000000 by 31 -> 1; ADD writing rd=0 -> r0 stays 0.
REQ-037 Opcode 0x11 -> illegal=1, pc+1, retire pulses; a following HALT -> halted=1, pc frozen, no further imem_req.
REQ-038 rst asserted in the same cycle as imem_ready in FETCH -> the fetched word is discarded, pc=0, and all outputs read 0 in the next cycle.

Source files
------------

// File: rtl/mc_core.sv
// mc_core: multi-cycle FETCH/DECODE/EXEC/WB core running a small MIPS-like
// subset, with a stalling instruction-fetch handshake.
module mc_core #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int PC_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] alu_result,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    state_t              r_state;
    logic                r_req;
    logic [31:0]         r_instr;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_alu;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_npc;
    logic                r_we;
    logic [IW-1:0]       r_wa;
    logic                r_halt_pend;
    logic                r_retire;
    logic                r_halted;
    logic                r_illegal;
    logic [DATA_W-1:0]   r_rf [NUM_REGS];

    logic [5:0]          w_op;
    logic [IW-1:0]       w_rs;
    logic [IW-1:0]       w_rt;
    logic [IW-1:0]       w_rd;
    logic [4:0]          w_sh;
    logic [5:0]          w_fn;
    logic signed [15:0]  w_imm;

    assign w_op  = r_instr[31:26];
    assign w_rs  = r_instr[21 +: IW];
    assign w_rt  = r_instr[16 +: IW];
    assign w_rd  = r_instr[11 +: IW];
    assign w_sh  = r_instr[10:6];
    assign w_fn  = r_instr[5:0];
    assign w_imm = r_instr[15:0];

    logic [DATA_W-1:0] w_res;
    logic              w_upd;
    logic              w_we;
    logic [IW-1:0]     w_wa;
    logic [PC_W-1:0]   w_npc;
    logic              w_bad;
    logic              w_halt;
    logic              w_big_sh;

    // Shift amounts at or beyond the datapath width flush to zero.
    assign w_big_sh = (int'(w_sh) >= DATA_W);

    always_comb begin
        w_res  = r_alu;
        w_upd  = 1'b0;
        w_we   = 1'b0;
        w_wa   = w_rd;
        w_npc  = r_pc + PC_W'(1);
        w_bad  = 1'b0;
        w_halt = 1'b0;
        unique case (w_op)
            6'h00: begin
                w_upd = 1'b1;
                w_we  = 1'b1;
                unique case (w_fn)
                    6'h20: w_res = r_a + r_b;
                    6'h22: w_res = r_a - r_b;
                    6'h24: w_res = r_a & r_b;
                    6'h25: w_res = r_a | r_b;
                    6'h2A: w_res = DATA_W'($signed(r_a) < $signed(r_b));
                    6'h00: w_res = w_big_sh ? '0 : (r_b << w_sh);
                    6'h02: w_res = w_big_sh ? '0 : (r_b >> w_sh);
                    default: begin
                        w_upd = 1'b0;
                        w_we  = 1'b0;
                        w_bad = 1'b1;
                    end
                endcase
            end
            6'h08: begin
                w_res = r_a + DATA_W'(w_imm);
                w_upd = 1'b1;
                w_we  = 1'b1;
                w_wa  = w_rt;
            end
            6'h04, 6'h05: begin
                w_res = r_a - r_b;
                w_upd = 1'b1;
                if ((r_a == r_b) == (w_op == 6'h04))
                    w_npc = r_pc + PC_W'(1) + PC_W'(w_imm);
            end
            6'h02: w_npc = r_instr[PC_W-1:0];
            6'h3F: begin
                w_halt = 1'b1;
                w_npc  = r_pc;
            end
            default: w_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_req       <= 1'b0;
            r_instr     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_alu       <= '0;
            r_pc        <= '0;
            r_npc       <= '0;
            r_we        <= 1'b0;
            r_wa        <= '0;
            r_halt_pend <= 1'b0;
            r_retire    <= 1'b0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
        end else begin
            r_retire <= 1'b0;
            unique case (r_state)
                S_FETCH: begin
                    if (r_req && imem_ready) begin
                        r_instr <= imem_rdata;
                        r_req   <= 1'b0;
                        r_state <= S_DECODE;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_a     <= (w_rs == '0) ? '0 : r_rf[w_rs];
                    r_b     <= (w_rt == '0) ? '0 : r_rf[w_rt];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_upd) r_alu <= w_res;
                    if (w_bad) r_illegal <= 1'b1;
                    r_we        <= w_we;
                    r_wa        <= w_wa;
                    r_npc       <= w_npc;
                    r_halt_pend <= w_halt;
                    r_retire    <= 1'b1;
                    r_state     <= S_WB;
                end
                S_WB: begin
                    if (r_we && r_wa != '0) r_rf[r_wa] <= r_alu;
                    r_pc <= r_npc;
                    if (r_halt_pend) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign alu_result = r_alu;
    assign retire     = r_retire;
    assign halted     = r_halted;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_mc_core.sv
// Bench for mc_core: feeds instructions through the fetch handshake and
// checks each retirement against an instruction-level reference model.
module tb_mc_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [15:0] pc;
    logic [31:0] alu_result;
    logic        retire;
    logic        halted;
    logic        illegal;

    mc_core dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .alu_result (alu_result),
        .retire     (retire),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_retire = 0;
    always @(posedge clk) cyc++;

    // Architectural reference state
    logic [31:0] mr [32];
    logic [15:0] mpc;
    logic [31:0] malu;
    logic        mill;
    logic        mhalt;

    function automatic void model_reset();
        foreach (mr[i]) mr[i] = 32'h0;
        mpc = 16'h0; malu = 32'h0; mill = 1'b0; mhalt = 1'b0;
    endfunction

    function automatic void model_wr(input int idx, input logic [31:0] v);
        malu = v;
        if (idx != 0) mr[idx] = v;
    endfunction

    function automatic void model_exec(input logic [31:0] w);
        int op, rs, rt, rd, sh, fn;
        logic [31:0] a, b, sx;
        logic [15:0] nxt;
        op = int'(w[31:26]); rs = int'(w[25:21]); rt = int'(w[20:16]);
        rd = int'(w[15:11]); sh = int'(w[10:6]);  fn = int'(w[5:0]);
        a = mr[rs]; b = mr[rt];
        sx = {{16{w[15]}}, w[15:0]};
        nxt = mpc + 16'd1;
        case (op)
            0: case (fn)
                'h20: model_wr(rd, a + b);
                'h22: model_wr(rd, a - b);
                'h24: model_wr(rd, a & b);
                'h25: model_wr(rd, a | b);
                'h2A: model_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                'h00: model_wr(rd, b << sh);
                'h02: model_wr(rd, b >> sh);
                default: mill = 1'b1;
            endcase
            'h08: model_wr(rt, a + sx);
            'h04, 'h05: begin
                malu = a - b;
                if ((op == 'h04) ? (a == b) : (a != b))
                    nxt = mpc + 16'd1 + sx[15:0];
            end
            'h02: nxt = w[15:0];
            'h3F: begin mhalt = 1'b1; nxt = mpc; end
            default: mill = 1'b1;
        endcase
        mpc = nxt;
    endfunction

    function automatic logic [31:0] rtype(input int rs, rt, rd, sh, fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, rs, rt, imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic run_instr(input logic [31:0] w, input int stall);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_req: imem_req=%b expected 1", imem_req);
            return;
        end
        checks++;
        if (imem_addr !== mpc) begin
            errors++;
            $display("FAIL fetch_addr: got %0d expected %0d", imem_addr, mpc);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== mpc) begin
                errors++;
                $display("FAIL stall_hold: req=%b addr=%0d expected 1/%0d",
                         imem_req, imem_addr, mpc);
            end
        end
        imem_ready = 1'b1; imem_rdata = w;
        @(posedge clk); #1;
        imem_ready = 1'b0; imem_rdata = $urandom;
        model_exec(w);
        n = 1;
        while (!retire && n < 10) begin @(posedge clk); #1; n++; end
        last_retire = cyc;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL latency: retire %0d cycles after accept expected 3", n);
        end
        checks++;
        if (alu_result !== malu) begin
            errors++;
            $display("FAIL alu_result: got %h expected %h (instr %h)",
                     alu_result, malu, w);
        end
        checks++;
        if (illegal !== mill) begin
            errors++;
            $display("FAIL illegal: got %b expected %b", illegal, mill);
        end
        @(posedge clk); #1;
        checks++;
        if (retire !== 1'b0 || pc !== mpc || halted !== mhalt) begin
            errors++;
            $display("FAIL post_wb: retire=%b pc=%0d halted=%b expected 0/%0d/%b",
                     retire, pc, halted, mpc, mhalt);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (imem_req !== 1'b0 || pc !== 16'h0 || alu_result !== 32'h0 ||
            retire !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0 ||
            imem_addr !== 16'h0) begin
            errors++;
            $display("FAIL %s: req=%b pc=%0d alu=%h ret=%b halt=%b ill=%b expected all 0",
                     tag, imem_req, pc, alu_result, retire, halted, illegal);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_zero_outputs("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_arith();
        int t1, t2, t3;
        run_instr(itype('h08, 0, 1, 5), 0);  t1 = last_retire;
        run_instr(itype('h08, 0, 2, -3), 0); t2 = last_retire;
        run_instr(rtype(1, 2, 3, 0, 'h20), 0); t3 = last_retire;
        checks++;
        if (t2 - t1 != 4 || t3 - t2 != 4) begin
            errors++;
            $display("FAIL retire_spacing: got %0d,%0d expected 4,4", t2 - t1, t3 - t2);
        end
        checks++;
        if (pc !== 16'd3) begin
            errors++;
            $display("FAIL arith_pc: got %0d expected 3", pc);
        end
        run_instr(rtype(3, 0, 0, 0, 'h25), 0);
        checks++;
        if (alu_result !== 32'd2) begin
            errors++;
            $display("FAIL arith_r3: got %h expected 2", alu_result);
        end
    endtask

    task automatic test_fetch_stall();
        run_instr(itype('h08, 0, 7, 'h1234), 5);
    endtask

    task automatic test_branch();
        run_instr(itype('h08, 0, 1, 7), 0);
        run_instr({6'h02, 26'd10}, 0);
        run_instr(itype('h04, 1, 1, -1), 1);
        checks++;
        if (pc !== 16'd10) begin
            errors++;
            $display("FAIL beq_taken_pc: got %0d expected 10", pc);
        end
        run_instr(itype('h05, 1, 1, 4), 0);
        checks++;
        if (pc !== 16'd11) begin
            errors++;
            $display("FAIL bne_not_taken_pc: got %0d expected 11", pc);
        end
    endtask

    task automatic test_alu_cases();
        run_instr(itype('h08, 0, 2, -1), 0);
        run_instr(itype('h08, 0, 1, 1), 0);
        run_instr(rtype(2, 1, 3, 0, 'h2A), 0);
        checks++;
        if (alu_result !== 32'd1) begin
            errors++;
            $display("FAIL slt_signed: got %h expected 1", alu_result);
        end
        run_instr(itype('h08, 0, 4, 1), 0);
        run_instr(rtype(0, 4, 4, 31, 'h00), 0);
        run_instr(rtype(0, 4, 5, 31, 'h02), 0);
        checks++;
        if (alu_result !== 32'd1) begin
            errors++;
            $display("FAIL srl_31: got %h expected 1", alu_result);
        end
        run_instr(rtype(1, 1, 0, 0, 'h20), 0);
        run_instr(rtype(0, 0, 6, 0, 'h25), 0);
        checks++;
        if (alu_result !== 32'd0) begin
            errors++;
            $display("FAIL r0_write: got %h expected 0", alu_result);
        end
    endtask

    task automatic test_random();
        int fns[7] = '{'h20, 'h22, 'h24, 'h25, 'h2A, 'h00, 'h02};
        for (int r = 1; r < 8; r++)
            run_instr(itype('h08, 0, r, int'($urandom_range(0, 65535))), 0);
        for (int k = 0; k < 40; k++) begin
            int kind, rs, rt, rd;
            kind = int'($urandom_range(0, 5));
            rs = int'($urandom_range(0, 7));
            rt = int'($urandom_range(0, 7));
            rd = int'($urandom_range(0, 7));
            case (kind)
                0, 1, 2: run_instr(rtype(rs, rt, rd, int'($urandom_range(0, 31)),
                                         fns[$urandom_range(0, 6)]),
                                   int'($urandom_range(0, 2)));
                3: run_instr(itype('h08, rs, rt, int'($urandom_range(0, 65535))),
                             int'($urandom_range(0, 2)));
                default: run_instr(itype(kind == 4 ? 'h04 : 'h05, rs, rt,
                                         int'($urandom_range(0, 65535))), 0);
            endcase
        end
    endtask

    task automatic test_illegal_halt();
        logic [15:0] hpc;
        run_instr(itype('h11, 1, 2, 3), 0);
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_set: got %b expected 1", illegal);
        end
        run_instr(32'hFC00_0000, 0);
        hpc = mpc;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== hpc || retire !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold: req=%b halted=%b pc=%0d ret=%b expected 0/1/%0d/0",
                         imem_req, halted, pc, retire, hpc);
            end
        end
    endtask

    task automatic test_reset_in_fetch();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run_instr(itype('h08, 0, 2, 9), 0);
        run_instr(itype('h11, 0, 0, 0), 0);
        imem_ready = 1'b1;
        imem_rdata = itype('h08, 0, 5, 'h55);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; imem_ready = 1'b0;
        model_reset();
        check_zero_outputs("reset_in_fetch");
        run_instr(rtype(2, 0, 0, 0, 'h25), 0);
        run_instr(rtype(5, 0, 0, 0, 'h25), 0);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_fetch_stall();
        test_branch();
        test_alu_cases();
        test_random();
        test_illegal_halt();
        test_reset_in_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
